// File: rtl/counter_cmd_sequencer.sv
// counter_cmd_sequencer: turns LOAD/UP/DOWN/WAIT commands into load_n/ce/up_down/data_load
// pulses for a downstream up/down counter, with optional saturation at its max/zero flags.
module counter_cmd_sequencer #(
   parameter int WIDTH = 4,
   parameter int STEPW = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [STEPW-1:0] cmd_steps,
   input  logic             cmd_sat,
   output logic             load_n,
   output logic             ce,
   output logic             up_down,
   output logic [WIDTH-1:0] data_load,
   input  logic             max_count,
   input  logic             zero,
   output logic             busy,
   output logic             done,
   output logic [1:0]       status,
   output logic [STEPW-1:0] steps_done
);
   localparam logic [1:0] OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_WAIT = 2'b11;
   localparam logic [1:0] ST_OK = 2'b00, ST_MAX = 2'b01, ST_MIN = 2'b10;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT, S_DONE} state_t;
   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d, status_q, status_d;
   logic             sat_q, sat_d, up_down_q, up_down_d;
   logic [STEPW-1:0] remaining_q, remaining_d, steps_done_q, steps_done_d;
   logic [WIDTH-1:0] data_load_q, data_load_d;
   logic             accept, limit;
   assign accept = cmd_valid && state_q == S_IDLE;
   assign limit  = op_q == OP_UP ? max_count : zero;
   // ce reacts to the counter flag in the same cycle so saturation never overshoots
   assign ce         = state_q == S_RUN && !(sat_q && limit);
   assign load_n     = state_q != S_LOAD;
   assign busy       = state_q != S_IDLE;
   assign cmd_ready  = state_q == S_IDLE;
   assign done       = state_q == S_DONE;
   assign status     = status_q;
   assign steps_done = steps_done_q;
   assign up_down    = up_down_q;
   assign data_load  = data_load_q;
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      sat_d        = sat_q;
      remaining_d  = remaining_q;
      steps_done_d = steps_done_q;
      status_d     = status_q;
      up_down_d    = up_down_q;
      data_load_d  = data_load_q;
      case (state_q)
         S_IDLE: if (accept) begin
            op_d         = cmd_op;
            sat_d        = cmd_sat;
            remaining_d  = cmd_steps;
            steps_done_d = '0;
            status_d     = ST_OK;
            data_load_d  = cmd_op == OP_LOAD ? cmd_data : data_load_q;
            up_down_d    = cmd_op == OP_UP ? 1'b1 : cmd_op == OP_DOWN ? 1'b0 : up_down_q;
            state_d      = cmd_op == OP_LOAD ? S_LOAD :
                           cmd_steps == '0   ? S_DONE :
                           cmd_op == OP_WAIT ? S_WAIT : S_RUN;
         end
         S_LOAD: state_d = S_DONE;
         S_RUN: if (ce) begin
            remaining_d  = remaining_q - 1'b1;
            steps_done_d = steps_done_q + 1'b1;
            state_d      = remaining_q == 1 ? S_DONE : S_RUN;
         end else begin
            status_d = op_q == OP_UP ? ST_MAX : ST_MIN;
            state_d  = S_DONE;
         end
         S_WAIT: begin
            remaining_d = remaining_q - 1'b1;
            state_d     = remaining_q == 1 ? S_DONE : S_WAIT;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         op_q         <= OP_LOAD;
         sat_q        <= 1'b0;
         remaining_q  <= '0;
         steps_done_q <= '0;
         status_q     <= ST_OK;
         up_down_q    <= 1'b0;
         data_load_q  <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         sat_q        <= sat_d;
         remaining_q  <= remaining_d;
         steps_done_q <= steps_done_d;
         status_q     <= status_d;
         up_down_q    <= up_down_d;
         data_load_q  <= data_load_d;
      end
   end
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb_counter_cmd_sequencer: directed bench driving the sequencer into a behavioural 4-bit counter.
module tb_counter_cmd_sequencer;
   logic       clk = 0, rst_n = 0;
   logic       cmd_valid = 0, cmd_ready, cmd_sat = 0;
   logic [1:0] cmd_op = 0, status;
   logic [3:0] cmd_data = 0, data_load;
   logic [7:0] cmd_steps = 0, steps_done;
   logic       load_n, ce, up_down, max_count, zero, busy, done;
   logic [3:0] count;
   logic       s_ld, s_ce, s_ud;
   logic [3:0] s_dl;
   int         passed = 0, total = 0, ce_cnt = 0, ld_cnt = 0, lat;
   counter_cmd_sequencer #(.WIDTH(4), .STEPW(8)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_steps(cmd_steps), .cmd_sat(cmd_sat), .load_n(load_n), .ce(ce),
      .up_down(up_down), .data_load(data_load), .max_count(max_count), .zero(zero), .busy(busy),
      .done(done), .status(status), .steps_done(steps_done));
   always #5 clk = ~clk;
   // counter model: controls sampled mid-cycle, applied on the next rising edge
   always @(negedge clk) begin
      s_ld = load_n; s_ce = ce; s_ud = up_down; s_dl = data_load;
      if (ce) ce_cnt++;
      if (!load_n) ld_cnt++;
   end
   always @(posedge clk or negedge rst_n)
      if (!rst_n) count <= 0;
      else if (!s_ld) count <= s_dl;
      else if (s_ce) count <= s_ud ? count + 4'd1 : count - 4'd1;
   assign max_count = count == 4'hf;
   assign zero      = count == 4'h0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask
   task automatic run(input string tag, input logic [1:0] op, input logic [3:0] d, input logic [7:0] st,
                      input logic s, input int e_lat, input logic [1:0] e_st, input int e_sd,
                      input int e_ce, input int e_ld, input int e_cnt);
      int ce0, ld0;
      @(negedge clk);
      cmd_op = op; cmd_data = d; cmd_steps = st; cmd_sat = s; cmd_valid = 1;
      ce0 = ce_cnt; ld0 = ld_cnt;
      @(posedge clk); #1 cmd_valid = 0; cmd_data = $urandom; cmd_steps = $urandom; cmd_op = $urandom;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!done && lat < 100);
      chk({tag, " latency"}, lat, e_lat);
      chk({tag, " status"}, status, e_st);
      chk({tag, " steps_done"}, steps_done, e_sd);
      chk({tag, " ce cycles"}, ce_cnt - ce0, e_ce);
      chk({tag, " load cycles"}, ld_cnt - ld0, e_ld);
      chk({tag, " count"}, count, e_cnt);
      chk({tag, " busy at done"}, busy, 1);
      @(negedge clk);
      chk({tag, " done/ready after"}, {done, cmd_ready}, 2'b01);
      chk({tag, " status held"}, status, e_st);
   endtask
   initial begin
      #12;
      chk("reset load_n/ce/up_down", {load_n, ce, up_down}, 3'b100);
      chk("reset data_load", data_load, 0);
      chk("reset done/busy/ready", {done, busy, cmd_ready}, 3'b001);
      chk("reset status/steps", {status, steps_done}, 0);
      @(negedge clk); rst_n = 1;
      run("load5", 2'b00, 4'b0101, 0, 0, 2, 0, 0, 0, 1, 5);
      run("up3", 2'b01, 0, 3, 0, 4, 0, 3, 3, 0, 8);
      chk("up3 up_down", up_down, 1);
      run("load13", 2'b00, 4'b1101, 0, 0, 2, 0, 0, 0, 1, 13);
      run("up5sat", 2'b01, 0, 5, 1, 4, 2'b01, 2, 2, 0, 15);
      chk("up5sat max_count", max_count, 1);
      run("up5sat again", 2'b01, 0, 5, 1, 2, 2'b01, 0, 0, 0, 15);
      run("load1", 2'b00, 4'b0001, 0, 0, 2, 0, 0, 0, 1, 1);
      run("down3 wrap", 2'b10, 0, 3, 0, 4, 0, 3, 3, 0, 14);
      chk("down3 up_down", up_down, 0);
      run("load1b", 2'b00, 4'b0001, 0, 0, 2, 0, 0, 0, 1, 1);
      run("down3sat", 2'b10, 0, 3, 1, 3, 2'b10, 1, 1, 0, 0);
      run("wait4", 2'b11, 0, 4, 0, 5, 0, 0, 0, 0, 0);
      run("up0", 2'b01, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      cmd_op = 2'b01; cmd_steps = 10; cmd_sat = 0; cmd_valid = 1;
      @(posedge clk); #1 cmd_valid = 0;
      @(negedge clk);
      chk("abort first cycle ce", ce, 1);
      @(negedge clk);
      rst_n = 0; #1;
      chk("abort ce/busy/done", {ce, busy, done}, 3'b000);
      chk("abort ready/load_n/up_down", {cmd_ready, load_n, up_down}, 3'b110);
      chk("abort steps_done", steps_done, 0);
      @(negedge clk); rst_n = 1;
      run("load9 after reset", 2'b00, 4'b1001, 0, 0, 2, 0, 0, 0, 1, 9);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
